// File: rtl/intersection_ctrl_pkg.sv
// Shared definitions for the intersection phase sequencer.
// This file holds the phase codes, the one-hot lamp encodings and the per-phase lamp decode.
package intersection_ctrl_pkg;

  // Phase codes. Codes 6 and 7 are unused and are treated as illegal.
  typedef enum logic [2:0] {
    M_GRN = 3'd0,
    M_YEL = 3'd1,
    CLR_A = 3'd2,
    S_GRN = 3'd3,
    S_YEL = 3'd4,
    CLR_B = 3'd5
  } phase_e;

  // One-hot lamp encoding, ordered as {R,Y,G}.
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;

  typedef struct packed {
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
  } lights_t;

  // Lamp pattern for each phase. Any code outside the legal set shows red on both roads.
  function automatic lights_t decode_lights(phase_e p);
    lights_t l;
    l = '{main_lamp: RED, side_lamp: RED};
    case (p)
      M_GRN:   l.main_lamp = GREEN;
      M_YEL:   l.main_lamp = YELLOW;
      S_GRN:   l.side_lamp = GREEN;
      S_YEL:   l.side_lamp = YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase duration timer.
// It counts up from zero after a synchronous clear. With sat asserted it holds at limit-1.
// The done output is high while count equals limit-1.
module intersection_ctrl_phase_timer #(
  parameter int CW = 4
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          clr,
  input  logic          sat,
  input  logic [CW:0]   limit,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW:0]   LIM_ONE = (CW+1)'(1);
  localparam logic [CW-1:0] INC     = CW'(1);

  assign done = ({1'b0, count} == (limit - LIM_ONE));

  // The count restarts on every phase entry. It freezes at the end of a saturating phase.
  always_ff @(posedge ck) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rs || clr) begin
      count <= '0;
    end else if (!(sat && done)) begin
      count <= count + INC;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Phase sequencer for a main/side intersection with a pedestrian crossing.
// The main road rests in green. A side car or a latched pedestrian request runs one full side cycle.
// The lamps are a zero-latency decode of the phase register. The walk lamp is registered.
module intersection_ctrl
  import intersection_ctrl_pkg::*;
#(
  parameter int CW       = 4,
  parameter int T_MG_MIN = 8,
  parameter int T_YEL    = 4,
  parameter int T_CLR    = 2,
  parameter int T_SG     = 6
) (
  input  logic          ck,
  input  logic          rs,
  input  logic          car_side,
  input  logic          ped_req,
  output logic [2:0]    main_light,
  output logic [2:0]    side_light,
  output logic          walk,
  output logic          ped_pending,
  output logic [2:0]    state,
  output logic [CW-1:0] counter
);

  phase_e        state_r;
  logic          pend_r;
  logic          walk_r;
  logic [CW:0]   limit;
  logic          done;
  logic          advance;
  logic          sat;
  logic [CW-1:0] count;
  lights_t       lights;

  // Select the duration of the current phase for the shared timer.
  always_comb begin
    // NOTE: each always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    limit = (CW+1)'(T_CLR);
    case (state_r)
      M_GRN:        limit = (CW+1)'(T_MG_MIN);
      M_YEL, S_YEL: limit = (CW+1)'(T_YEL);
      CLR_A, CLR_B: limit = (CW+1)'(T_CLR);
      S_GRN:        limit = (CW+1)'(T_SG);
      default:      limit = (CW+1)'(T_CLR);
    endcase
  end

  // Decide whether this edge leaves the current phase. An illegal code always leaves.
  always_comb begin
    advance = 1'b1;
    case (state_r)
      M_GRN:                      advance = done && (car_side || pend_r);
      M_YEL, CLR_A, S_GRN, S_YEL,
      CLR_B:                      advance = done;
      default:                    advance = 1'b1;
    endcase
  end

  assign sat = (state_r == M_GRN);

  intersection_ctrl_phase_timer #(.CW(CW)) u_timer (
    .ck    (ck),
    .rs    (rs),
    .clr   (advance),
    .sat   (sat),
    .limit (limit),
    .count (count),
    .done  (done)
  );

  // Phase sequencing, the pedestrian request latch and the walk lamp register.
  always_ff @(posedge ck) begin
    if (!rs) begin
      state_r <= M_GRN;
      pend_r  <= 1'b0;
      walk_r  <= 1'b0;
    end else begin
      // A new press has priority over the clear that happens when S_GRN is entered.
      if (ped_req) begin
        pend_r <= 1'b1;
      end else if (state_r == CLR_A && advance) begin
        pend_r <= 1'b0;
      end

      case (state_r)
        M_GRN: if (advance) state_r <= M_YEL;
        M_YEL: if (advance) state_r <= CLR_A;
        CLR_A: if (advance) begin
          state_r <= S_GRN;
          // The walk lamp takes the request value from before this edge.
          walk_r  <= pend_r;
        end
        S_GRN: if (advance) begin
          state_r <= S_YEL;
          walk_r  <= 1'b0;
        end
        S_YEL: if (advance) state_r <= CLR_B;
        CLR_B: if (advance) state_r <= M_GRN;
        default: begin
          state_r <= M_GRN;
          walk_r  <= 1'b0;
        end
      endcase
    end
  end

  assign lights      = decode_lights(state_r);
  assign main_light  = lights.main_lamp;
  assign side_light  = lights.side_lamp;
  assign walk        = walk_r;
  assign ped_pending = pend_r;
  assign state       = state_r;
  assign counter     = count;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl.
// It runs directed scenarios and then randomized traffic, checked against a behavioural phase model.
module tb_intersection_ctrl;

  localparam int CW = 4;

  logic          ck = 1'b0;
  logic          rs = 1'b0;
  logic          car_side = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    main_light;
  logic [2:0]    side_light;
  logic          walk;
  logic          ped_pending;
  logic [2:0]    state;
  logic [CW-1:0] counter;

  int test_cnt = 0;
  int fail_cnt = 0;

  intersection_ctrl #(.CW(CW)) dut (
    .ck          (ck),
    .rs          (rs),
    .car_side    (car_side),
    .ped_req     (ped_req),
    .main_light  (main_light),
    .side_light  (side_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state       (state),
    .counter     (counter)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model. Phases run in a ring of fixed durations.
  // M_GRN has a minimum dwell instead of a fixed duration.
  int   dur [6]           = '{8, 4, 2, 6, 4, 2};
  logic [2:0] main_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int   m_phase = 0;
  int   m_cnt   = 0;
  bit   m_pend  = 0;
  bit   m_walk  = 0;
  bit   m_illegal = 0;

  task automatic model_step(input bit r, input bit car, input bit ped);
    bit leave;
    int nxt;
    if (!r) begin
      m_phase = 0; m_cnt = 0; m_pend = 0; m_walk = 0; m_illegal = 0;
      return;
    end
    if (m_illegal) begin
      m_phase = 0; m_cnt = 0; m_walk = 0; m_pend = m_pend | ped; m_illegal = 0;
      return;
    end
    leave = (m_cnt == dur[m_phase] - 1) && (m_phase != 0 || car || m_pend);
    nxt   = leave ? (m_phase + 1) % 6 : m_phase;
    if (leave && nxt == 3) m_walk = m_pend;
    else if (leave && m_phase == 3) m_walk = 0;
    if (ped) m_pend = 1;
    else if (leave && nxt == 3) m_pend = 0;
    if (leave) m_cnt = 0;
    else if (!(m_phase == 0 && m_cnt == dur[0] - 1)) m_cnt++;
    m_phase = nxt;
  endtask

  task automatic compare_all();
    check("state",   32'(state),       32'(m_phase));
    check("counter", 32'(counter),     32'(m_cnt));
    check("pending", 32'(ped_pending), 32'(m_pend));
    check("walk",    32'(walk),        32'(m_walk));
    check("main",    32'(main_light),  32'(main_tab[m_phase]));
    check("side",    32'(side_light),  32'(side_tab[m_phase]));
    check("inv_main_onehot", 32'($onehot(main_light)), 32'd1);
    check("inv_side_onehot", 32'($onehot(side_light)), 32'd1);
    check("inv_conflict", 32'(main_light != 3'b100 && side_light != 3'b100), 32'd0);
    check("inv_walk", 32'(walk && state != 3'd3), 32'd0);
  endtask

  // Advance one clock with the current inputs, then compare the DUT with the model at the falling edge.
  task automatic tick();
    model_step(rs, car_side, ped_req);
    @(posedge ck);
    @(negedge ck);
    compare_all();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    bit reached;
    while (state != s && n < budget) begin
      tick();
      n++;
    end
    reached = (state == s);
    check(tag, 32'(reached), 32'd1);
  endtask

  int expd;
  int n;
  int walk_cycles;

  initial begin
    @(negedge ck);
    // Apply reset for two edges, then release it. Cycle 0 follows.
    rs = 1'b0;
    tick();
    tick();
    rs = 1'b1;

    // Test 3: a car is present from cycle 2. This is a car-only side cycle, so walk stays off.
    for (int k = 0; k < 28; k++) begin
      car_side = (k >= 2);
      expd = (k < 8) ? 0 : (k < 12) ? 1 : (k < 14) ? 2 : (k < 20) ? 3 :
             (k < 24) ? 4 : (k < 26) ? 5 : 0;
      check("t3_state", 32'(state), 32'(expd));
      check("t3_walk", 32'(walk), 32'd0);
      tick();
    end
    car_side = 1'b0;

    // Test 2: with no requests, the controller holds in M_GRN and the counter saturates.
    for (int k = 0; k < 50; k++) tick();
    check("t2_state", 32'(state), 32'd0);
    check("t2_counter", 32'(counter), 32'd7);

    // Test 4: a one-cycle pedestrian pulse while main green has saturated.
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("t4_pending_set", 32'(ped_pending), 32'd1);
    walk_cycles = 0;
    n = 0;
    while (n < 40) begin
      tick();
      if (walk) walk_cycles++;
      n++;
    end
    check("t4_walk_len", 32'(walk_cycles), 32'd6);
    check("t4_pending_clr", 32'(ped_pending), 32'd0);

    // Test 5: a press on the S_GRN entry edge is deferred to the next side cycle.
    car_side = 1'b1;
    wait_state(3'd2, 40, "t5_reach_clra");
    while (state == 3'd2 && counter != 1) tick();
    car_side = 1'b0;
    ped_req  = 1'b1;
    tick();
    ped_req  = 1'b0;
    check("t5_entry_state", 32'(state), 32'd3);
    check("t5_entry_walk", 32'(walk), 32'd0);
    check("t5_entry_pend", 32'(ped_pending), 32'd1);
    wait_state(3'd0, 40, "t5_back_mgrn");
    n = 0;
    while (state == 3'd0 && n < 50) begin
      tick();
      n++;
    end
    check("t5_mgrn_len", 32'(n), 32'd8);
    wait_state(3'd3, 20, "t5_reach_sgrn");
    check("t5_walk_on", 32'(walk), 32'd1);
    wait_state(3'd0, 40, "t5_return");

    // Test 1: reset held for two edges in the middle of S_YEL.
    car_side = 1'b1;
    wait_state(3'd4, 60, "t1_reach_syel");
    tick();
    car_side = 1'b0;
    rs = 1'b0;
    tick();
    tick();
    check("t1_state", 32'(state), 32'd0);
    check("t1_counter", 32'(counter), 32'd0);
    check("t1_main", 32'(main_light), 32'h1);
    check("t1_side", 32'(side_light), 32'h4);
    check("t1_walk", 32'(walk), 32'd0);
    rs = 1'b1;

    // Test 6: deposit illegal code 6. Both roads go red, then the controller recovers to M_GRN.
    for (int k = 0; k < 10; k++) tick();
    force dut.state_r = intersection_ctrl_pkg::phase_e'(3'd6);
    #1;
    check("t6_state", 32'(state), 32'd6);
    check("t6_main_red", 32'(main_light), 32'h4);
    check("t6_side_red", 32'(side_light), 32'h4);
    release dut.state_r;
    m_illegal = 1;
    tick();
    check("t6_recover", 32'(state), 32'd0);

    // Randomized traffic, with an occasional reset.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) car_side = ~car_side;
      ped_req = ($urandom_range(0, 19) == 0);
      rs      = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
